// File: rtl/pc_unit.sv
// Program-counter stage: registers the next PC from the branch decision, traps on
// misaligned taken targets, freezes after a retiring halt, and counts retired instructions.
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        NextPCSrc,
    input  logic [31:0] BranchTarget,
    input  logic        IsJALR,
    input  logic        Halt,
    input  logic        Stall,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Misaligned,
    output logic [31:0] TrapPC,
    output logic        Halted,
    output logic [31:0] InstRet
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instret;
    logic [31:0] w_instret_next;
    logic [31:0] r_trap_pc;
    logic [31:0] w_trap_pc_next;
    logic        r_misaligned;
    logic        w_misaligned_next;
    logic [31:0] w_tgt;
    logic [31:0] w_pc_plus4;
    logic        w_advance;

    // JALR clears bit 0; a remaining nonzero bit 1 still faults.
    assign w_tgt      = IsJALR ? {BranchTarget[31:1], 1'b0} : BranchTarget;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_advance  = (r_state == ST_RUN) && !Stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_VECTOR;
            r_instret    <= 32'd0;
            r_trap_pc    <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_instret    <= w_instret_next;
            r_trap_pc    <= w_trap_pc_next;
            r_misaligned <= w_misaligned_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_advance && Halt) begin
            w_state_next = ST_HALT;
        end
    end

    // Halt outranks the branch decision, so a halting instruction never traps.
    always_comb begin
        w_pc_next         = r_pc;
        w_instret_next    = r_instret;
        w_trap_pc_next    = r_trap_pc;
        w_misaligned_next = 1'b0;
        if (w_advance) begin
            if (Halt) begin
                w_instret_next = r_instret + 32'd1;
            end else if (NextPCSrc && (w_tgt[1:0] != 2'b00)) begin
                w_pc_next         = TRAP_VECTOR;
                w_trap_pc_next    = r_pc;
                w_misaligned_next = 1'b1;
            end else if (NextPCSrc) begin
                w_pc_next      = w_tgt;
                w_instret_next = r_instret + 32'd1;
            end else begin
                w_pc_next      = w_pc_plus4;
                w_instret_next = r_instret + 32'd1;
            end
        end
    end

    assign PC         = r_pc;
    assign PCPlus4    = w_pc_plus4;
    assign Misaligned = r_misaligned;
    assign TrapPC     = r_trap_pc;
    assign Halted     = (r_state == ST_HALT);
    assign InstRet    = r_instret;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed test-plan sequences plus randomized traffic, checked
// against an architectural model of the PC stage.
module tb_pc_unit;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        NextPCSrc = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic        IsJALR = 1'b0;
    logic        Halt = 1'b0;
    logic        Stall = 1'b0;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Misaligned;
    logic [31:0] TrapPC;
    logic        Halted;
    logic [31:0] InstRet;

    int n_vec  = 0;
    int n_fail = 0;

    // Architectural model state
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_trap;
    logic        m_mis;
    logic        m_halted;

    pc_unit #(
        .RESET_VECTOR(RESET_VECTOR),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .NextPCSrc   (NextPCSrc),
        .BranchTarget(BranchTarget),
        .IsJALR      (IsJALR),
        .Halt        (Halt),
        .Stall       (Stall),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Misaligned  (Misaligned),
        .TrapPC      (TrapPC),
        .Halted      (Halted),
        .InstRet     (InstRet)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".PC"},         PC,                m_pc);
        check_eq({tag, ".PCPlus4"},    PCPlus4,           m_pc + 32'd4);
        check_eq({tag, ".Misaligned"}, {31'd0, Misaligned}, {31'd0, m_mis});
        check_eq({tag, ".TrapPC"},     TrapPC,            m_trap);
        check_eq({tag, ".Halted"},     {31'd0, Halted},   {31'd0, m_halted});
        check_eq({tag, ".InstRet"},    InstRet,           m_instret);
    endtask

    task automatic model_reset();
        m_pc      = RESET_VECTOR;
        m_instret = 0;
        m_trap    = 0;
        m_mis     = 0;
        m_halted  = 0;
    endtask

    // One rising edge of the architectural rules.
    task automatic model_edge(input logic nps, input logic [31:0] bt, input logic jalr,
                              input logic hlt, input logic stl);
        logic [31:0] t;
        t     = jalr ? (bt & ~32'd1) : bt;
        m_mis = 0;
        if (m_halted || stl) begin
            // nothing moves
        end else if (hlt) begin
            m_instret = m_instret + 1;
            m_halted  = 1;
        end else if (nps && (t % 4 != 0)) begin
            m_trap = m_pc;
            m_pc   = TRAP_VECTOR;
            m_mis  = 1;
        end else begin
            m_pc      = nps ? t : m_pc + 4;
            m_instret = m_instret + 1;
        end
    endtask

    // Inputs are driven 1 time unit after an edge and checked 1 unit after the next.
    task automatic apply(input string tag, input logic nps, input logic [31:0] bt,
                         input logic jalr, input logic hlt, input logic stl);
        NextPCSrc    = nps;
        BranchTarget = bt;
        IsJALR       = jalr;
        Halt         = hlt;
        Stall        = stl;
        @(posedge clk);
        model_edge(nps, bt, jalr, hlt, stl);
        #1;
        check_all(tag);
    endtask

    // Reset asserted mid-cycle; outputs must change without any clock edge.
    task automatic async_reset(input string tag);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Sequential and wrap
        apply("seq0", 0, 32'h0, 0, 0, 0);
        apply("seq1", 0, 32'h0, 0, 0, 0);
        apply("seq2", 0, 32'h0, 0, 0, 0);
        check_eq("seq.instret3", InstRet, 32'd3);
        apply("force_top", 1, 32'hFFFF_FFFC, 0, 0, 0);
        apply("wrap", 0, 32'h0, 0, 0, 0);
        check_eq("wrap.pc0", PC, 32'h0);

        // Taken branch and JALR
        apply("to8a", 0, 32'h0, 0, 0, 0);
        apply("to8b", 0, 32'h0, 0, 0, 0);
        apply("br40", 1, 32'h40, 0, 0, 0);
        check_eq("br40.pc", PC, 32'h40);
        apply("jalr81", 1, 32'h81, 1, 0, 0);
        check_eq("jalr81.pc", PC, 32'h80);
        check_eq("jalr81.nomis", {31'd0, Misaligned}, 32'd0);

        // Misaligned trap then back-to-back trap
        apply("trap42", 1, 32'h42, 0, 0, 0);
        check_eq("trap42.pc", PC, 32'h100);
        check_eq("trap42.trappc", TrapPC, 32'h80);
        check_eq("trap42.mis", {31'd0, Misaligned}, 32'd1);
        apply("trap_b2b", 1, 32'h203, 1, 0, 0);
        apply("after_trap", 0, 32'h0, 0, 0, 0);
        check_eq("after_trap.mis", {31'd0, Misaligned}, 32'd0);

        // Stall priority over halt and branch
        apply("stall0", 1, 32'h42, 0, 1, 1);
        apply("stall1", 1, 32'h42, 0, 1, 1);
        apply("halt_retire", 1, 32'h42, 0, 1, 0);
        check_eq("halt.halted", {31'd0, Halted}, 32'd1);

        // Halt freeze
        for (int i = 0; i < 5; i++) begin
            apply("frozen", i[0], $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Async reset while halted with InstRet=7
        async_reset("rst_mid");
        for (int i = 0; i < 6; i++) apply("seq7", 0, 32'h0, 0, 0, 0);
        apply("halt7", 0, 32'h0, 0, 1, 0);
        check_eq("halt7.instret", InstRet, 32'd7);
        apply("halt7_hold", 1, 32'h44, 0, 0, 0);
        async_reset("rst_halt");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] bt;
            bt = $urandom;
            if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) bt[1:0] = 2'b01;
            apply("rand", 1'($urandom_range(0, 1)), bt, 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 7) == 0));
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the monocycle processor, directly downstream of the BranchUnit. Each cycle it consumes the BranchUnit's NextPCSrc decision together with the ALU-computed target and registers the next PC. It produces PC and PC+4 for instruction fetch and the JAL/JALR link write-back. It also detects misaligned control-transfer targets and redirects to a trap vector, freezes on a halt instruction, and counts retired instructions.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded when a taken target is misaligned
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- NextPCSrc  in  1  from BranchUnit; 1 = take BranchTarget, 0 = sequential
- BranchTarget  in  32  ALU result: PC+imm for branch/JAL, rs1+imm for JALR
- IsJALR  in  1  current instruction is JALR; bit 0 of target is cleared
- Halt  in  1  current instruction is ECALL/EBREAK; stop after it retires
- Stall  in  1  hold all state this cycle; instruction not complete
- PC  out  32  current PC, registered
- PCPlus4  out  32  PC + 4, combinational, modulo 2^32
- Misaligned  out  1  one-cycle pulse, registered, set on trap redirect
- TrapPC  out  32  PC of the most recent faulting instruction
- Halted  out  1  1 while in HALT state
- InstRet  out  32  retired-instruction counter, wraps

## Operation
- FSM has two states: RUN and HALT. Reset enters RUN. RUN goes to HALT on a retiring Halt. HALT is left only by rst.
- Effective target: Tgt = IsJALR ? {BranchTarget[31:1],1'b0} : BranchTarget.
- In RUN, priority per edge is as follows:
  - Stall=1: PC, InstRet, TrapPC and the state hold. Misaligned is 0. Halt and NextPCSrc are ignored.
  - Halt=1: PC holds. InstRet is incremented. State goes to HALT. NextPCSrc is ignored.
  - NextPCSrc=1 and Tgt[1:0]≠0: PC ← TRAP_VECTOR, TrapPC ← PC, Misaligned ← 1. InstRet is not incremented, because the faulting instruction does not retire.
  - NextPCSrc=1 and aligned: PC ← Tgt, InstRet +1.
  - Otherwise: PC ← PCPlus4, InstRet +1.
- In HALT, all inputs are ignored. PC, InstRet and TrapPC are frozen. Misaligned is 0. Halted is 1.
- Misaligned is 0 on every edge that does not perform a trap redirect.
- Arithmetic: PC+4 and InstRet+1 are 32-bit, modulo 2^32. 0xFFFF_FFFC+4 = 0x0000_0000, and 0xFFFF_FFFF+1 = 0.
- PC stays word-aligned: a misaligned value is never loaded into PC. RESET_VECTOR and TRAP_VECTOR must be multiples of 4.

## Timing
- Reset values, applied immediately on rst assertion with no clock needed: PC=RESET_VECTOR, PCPlus4=RESET_VECTOR+4, Misaligned=0, TrapPC=0, Halted=0, InstRet=0, state=RUN.
- rst asserted mid-operation, including in HALT or in the same cycle as a trap: all state returns to the reset values asynchronously. The first update after deassertion happens on the next rising edge with rst=0.
- Latency: inputs sampled at edge N are reflected on PC/InstRet/TrapPC/Misaligned/Halted after edge N. PCPlus4 follows PC combinationally.
- Halted rises after the edge that retires Halt. On that edge PC keeps the halt instruction's address.
- Simultaneous inputs:
  - Stall+Halt: stall wins, and Halt is re-evaluated on the next unstalled edge.
  - Halt+NextPCSrc: halt wins, and no trap is taken even if the target is misaligned.
- Misaligned is high for exactly one cycle per trap. Back-to-back traps produce consecutive pulses, and TrapPC is updated each time.

## Test plan
- Sequential and wrap: reset, then 3 edges with NextPCSrc=0 → PC 0x0→0x4→0x8→0xC, InstRet=3. Force PC to 0xFFFF_FFFC via a taken target, then one sequential edge → PC=0x0.
- Taken branch and JALR: PC=0x8, NextPCSrc=1, BranchTarget=0x40 → PC=0x40. Then IsJALR=1, BranchTarget=0x81 → PC=0x80, with no trap.
- Misaligned trap: PC=0x80, NextPCSrc=1, BranchTarget=0x42 → PC=0x100, TrapPC=0x80, Misaligned=1 for exactly one cycle, InstRet unchanged.
- Stall priority: Stall=1 with NextPCSrc=1 and Halt=1 for 2 edges → PC, InstRet and state unchanged. Release the stall → Halt retires, InstRet+1, Halted=1.
- Halt freeze: after Halted=1, toggle NextPCSrc/BranchTarget for 5 edges → PC and InstRet frozen, Misaligned=0.
- Async reset: assert rst between edges while in HALT with InstRet=7 → PC=RESET_VECTOR, InstRet=0 and Halted=0 before the next edge.
